unidade_controle_multiciclo: RTL and testbench

Control unit for the multicycle processor: it owns the step counter (`Tstep`) and decodes the instruction register into per-step datapath enables. It drives register-in/out selects, `A`/`G` loads, the ALU operation, the `DIN` bus driver and `Done`. It sits beside the datapath (R0–R7, A, G, IR, bus mux) inside `processador_multiciclo`, replacing ad-hoc decode logic with a single sequencer.

---
 rtl/processador_pkg.sv | 21 ++
 rtl/unidade_controle_multiciclo_if.sv | 30 +++
 rtl/decod_3para8.sv | 7 +
 rtl/unidade_controle_multiciclo.sv | 111 +++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/processador_pkg.sv
// Shared ISA constants for the multicycle processor: opcodes, step encoding, field widths.
package processador_pkg;

  localparam int OPC_W = 3;
  localparam int REG_W = 3;
  localparam int NUM_REGS = 1 << REG_W;

  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Controller <-> datapath signal bundle; master is the control unit, slave the datapath.
interface unidade_controle_multiciclo_if;
  import processador_pkg::*;

  logic                               Run;
  logic [OPC_W+2*REG_W-1:0]           IR;
  logic                               G_nz;
  logic                               IRin;
  logic [NUM_REGS-1:0]                Rin;
  logic [NUM_REGS-1:0]                Rout;
  logic                               Ain;
  logic                               Gin;
  logic                               Gout;
  logic                               DINout;
  logic                               AddSub;
  logic                               Done;
  logic [1:0]                         Tstep;
  logic                               Illegal;
  logic [15:0]                        InstrCount;

  modport master (
    input  Run, IR, G_nz,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep, Illegal, InstrCount
  );

  modport slave (
    output Run, IR, G_nz,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep, Illegal, InstrCount
  );
endinterface

// File: rtl/decod_3para8.sv
// Combinational 3-to-8 one-hot decoder for register fields.
module decod_3para8 (
  input  logic [2:0] w,
  output logic [7:0] y
);
  assign y = 8'b0000_0001 << w;
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle sequencer: step counter, completed-instruction counter and per-step decode
// of IR into datapath enables.
module unidade_controle_multiciclo
  import processador_pkg::*;
(
  input logic                          Clock,
  input logic                          Reset,
  unidade_controle_multiciclo_if.master bus
);

  step_t             step, step_nxt;
  logic [15:0]       instr_count;
  logic [OPC_W-1:0]  opcode;
  logic [7:0]        x_hot, y_hot;

  logic              irin, ain, gin, gout, dinout, addsub, done, illegal;
  logic [7:0]        rin, rout;

  assign opcode = bus.IR[8:6];

  decod_3para8 u_dec_x (.w(bus.IR[5:3]), .y(x_hot));
  decod_3para8 u_dec_y (.w(bus.IR[2:0]), .y(y_hot));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step        <= T0;
      instr_count <= '0;
    end else begin
      step <= step_nxt;
      if (done) instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    irin    = 1'b0;
    rin     = '0;
    rout    = '0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    dinout  = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    step_nxt = step;

    case (step)
      T0: irin = bus.Run;
      T1: begin
        case (opcode)
          OP_MV:   begin rout = y_hot; rin = x_hot; done = 1'b1; end
          OP_MVI:  begin dinout = 1'b1; rin = x_hot; done = 1'b1; end
          OP_ADD,
          OP_SUB:  begin rout = x_hot; ain = 1'b1; end
          OP_MVNZ: begin
            if (bus.G_nz) begin
              rout = y_hot;
              rin  = x_hot;
            end
            done = 1'b1;
          end
          default: begin done = 1'b1; illegal = 1'b1; end
        endcase
      end
      T2: begin
        rout   = y_hot;
        gin    = 1'b1;
        addsub = (opcode == OP_SUB);
      end
      T3: begin
        gout = 1'b1;
        rin  = x_hot;
        done = 1'b1;
      end
      default: ;
    endcase

    // Only T0 waits on Run; every other step either finishes or advances.
    if (done)             step_nxt = T0;
    else if (step == T0)  step_nxt = bus.Run ? T1 : T0;
    else                  step_nxt = step_t'(step + 2'd1);

    // Reset silences every enable so an abandoned instruction writes nothing.
    if (Reset) begin
      irin    = 1'b0;
      rin     = '0;
      rout    = '0;
      ain     = 1'b0;
      gin     = 1'b0;
      gout    = 1'b0;
      dinout  = 1'b0;
      addsub  = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

  assign bus.IRin       = irin;
  assign bus.Rin        = rin;
  assign bus.Rout       = rout;
  assign bus.Ain        = ain;
  assign bus.Gin        = gin;
  assign bus.Gout       = gout;
  assign bus.DINout     = dinout;
  assign bus.AddSub     = addsub;
  assign bus.Done       = done;
  assign bus.Illegal    = illegal;
  assign bus.Tstep      = step;
  assign bus.InstrCount = instr_count;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit: hand-computed per-step enables and counters.
module tb_unidade_controle_multiciclo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  unidade_controle_multiciclo_if u_if ();

  unidade_controle_multiciclo dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Illegal, Tstep}
  function automatic logic [25:0] observed();
    return {u_if.IRin, u_if.Rin, u_if.Rout, u_if.Ain, u_if.Gin, u_if.Gout,
            u_if.DINout, u_if.AddSub, u_if.Done, u_if.Illegal, u_if.Tstep};
  endfunction

  task automatic chk_out(input string tag, input logic irin, input logic [7:0] rin,
                         input logic [7:0] rout, input logic ain, input logic gin,
                         input logic gout, input logic dinout, input logic addsub,
                         input logic done, input logic illegal, input logic [1:0] ts);
    logic [25:0] exp_v, obs_v;
    exp_v = {irin, rin, rout, ain, gin, gout, dinout, addsub, done, illegal, ts};
    obs_v = observed();
    checks++;
    assert (obs_v === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp_c);
    checks++;
    assert (u_if.InstrCount === exp_c)
      else begin
        errors++;
        $error("FAIL %s: observed InstrCount %h expected %h", tag, u_if.InstrCount, exp_c);
      end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if.Run  = 1'b1;
    u_if.IR   = 9'b000_000_000;
    u_if.G_nz = 1'b0;
    #1;
    // Under reset everything is forced low even with Run high.
    chk_out("reset_outputs", 0, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    step_clk();
    chk_cnt("reset_count", 16'h0000);

    // mvi R2, #1
    rst = 1'b0;
    u_if.IR = 9'b001_010_000;
    #1;
    chk_out("mvi_T0", 1, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    step_clk();
    chk_out("mvi_T1", 0, 8'h04, 8'h00, 0,0,0,1,0,1,0, 2'd1);
    step_clk();
    chk_cnt("mvi_count", 16'h0001);
    u_if.Run = 1'b0;
    #1;
    chk_out("mvi_back_T0", 0, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);

    // Run low: idle in T0
    for (int i = 0; i < 5; i++) begin
      step_clk();
      chk_out("idle_T0", 0, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    end

    // sub R4, R2 with Run dropped in T2
    u_if.Run = 1'b1;
    u_if.IR  = 9'b011_100_010;
    #1;
    chk_out("sub_T0", 1, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    step_clk();
    chk_out("sub_T1", 0, 8'h00, 8'h10, 1,0,0,0,0,0,0, 2'd1);
    step_clk();
    u_if.Run = 1'b0;
    #1;
    chk_out("sub_T2", 0, 8'h00, 8'h04, 0,1,0,0,1,0,0, 2'd2);
    step_clk();
    chk_out("sub_T3", 0, 8'h10, 8'h00, 0,0,1,0,0,1,0, 2'd3);
    step_clk();
    chk_cnt("sub_count", 16'h0002);

    // mvnz R7, R5, taken then not taken, back-to-back
    u_if.Run  = 1'b1;
    u_if.IR   = 9'b100_111_101;
    u_if.G_nz = 1'b1;
    step_clk();
    chk_out("mvnz_nz_T1", 0, 8'h80, 8'h20, 0,0,0,0,0,1,0, 2'd1);
    step_clk();
    u_if.G_nz = 1'b0;
    #1;
    chk_out("b2b_T0", 1, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    step_clk();
    chk_out("mvnz_z_T1", 0, 8'h00, 8'h00, 0,0,0,0,0,1,0, 2'd1);
    step_clk();
    chk_cnt("mvnz_count", 16'h0004);

    // add R1, R3 abandoned by reset in T2
    u_if.IR = 9'b010_001_011;
    step_clk();
    chk_out("add_T1", 0, 8'h00, 8'h02, 1,0,0,0,0,0,0, 2'd1);
    step_clk();
    chk_out("add_T2", 0, 8'h00, 8'h08, 0,1,0,0,0,0,0, 2'd2);
    rst = 1'b1;
    #1;
    chk_out("add_T2_reset", 0, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd2);
    step_clk();
    rst = 1'b0;
    #1;
    chk_out("post_reset_T0", 1, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);
    chk_cnt("post_reset_count", 16'h0000);

    // Illegal opcode
    u_if.IR = 9'b111_000_000;
    step_clk();
    chk_out("illegal_T1", 0, 8'h00, 8'h00, 0,0,0,0,0,1,1, 2'd1);
    step_clk();
    chk_cnt("illegal_count", 16'h0001);

    // Counter wrap via mv R3, R3
    u_if.Run = 1'b0;
    force dut.instr_count = 16'hFFFF;
    step_clk();
    release dut.instr_count;
    #1;
    chk_cnt("forced_count", 16'hFFFF);
    u_if.Run = 1'b1;
    u_if.IR  = 9'b000_011_011;
    step_clk();
    chk_out("mv_same_T1", 0, 8'h08, 8'h08, 0,0,0,0,0,1,0, 2'd1);
    u_if.Run = 1'b0;
    step_clk();
    chk_cnt("wrap_count", 16'h0000);
    chk_out("wrap_T0", 0, 8'h00, 8'h00, 0,0,0,0,0,0,0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
